// File: rtl/mx_scale_buf.sv
// MX block scaling buffer: collects one block of unsigned magnitudes, finds the
// shared exponent (MSB position of the OR of all magnitudes) and replays the
// block left-normalised so the block maximum has its MSB set.
module mx_scale_buf #(
  parameter int width_i     = 8,
  parameter int block_size  = 32,
  parameter int width_shift = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [width_i-1:0]           i_num,
  input  logic                         i_sign,
  input  logic [width_shift-1:0]       i_shift_cfg,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [width_i-1:0]           o_num,
  output logic                         o_sign,
  output logic [width_shift-1:0]       o_shift,
  output logic [$clog2(width_i):0]     o_scale,
  output logic                         o_zero_blk,
  output logic                         o_last
);

  localparam int cnt_w   = $clog2(block_size);
  localparam int scale_w = $clog2(width_i) + 1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SCALE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [cnt_w-1:0]       wr_cnt;
  logic [cnt_w-1:0]       rd_cnt;
  logic [cnt_w-1:0]       rd_nxt;
  logic [cnt_w-1:0]       rd_sel;
  logic [width_i-1:0]     or_acc;
  logic [scale_w-1:0]     lz_min;
  logic [scale_w-1:0]     lz_s;
  logic [scale_w-1:0]     shamt;
  logic                   zero_s;
  logic                   accept;
  logic                   xfer;
  logic                   last_wr;
  logic                   last_rd;
  logic [width_i-1:0]     mag_next;
  logic                   sign_next;
  logic [width_i:0]       buffer [block_size];

  // Leading-zero count; an all-zero vector reports width_i.
  function automatic logic [scale_w-1:0] lzc(input logic [width_i-1:0] v);
    logic [scale_w-1:0] n;
    logic               found;
    n     = scale_w'(width_i);
    found = 1'b0;
    for (int i = width_i - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = scale_w'(width_i - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  assign accept  = i_valid && (state == FILL);
  assign xfer    = i_ready && (state == DRAIN);
  assign last_wr = (wr_cnt == cnt_w'(block_size - 1));
  assign last_rd = (rd_cnt == cnt_w'(block_size - 1));
  assign rd_nxt  = rd_cnt + {{(cnt_w-1){1'b0}}, 1'b1};
  assign lz_s    = lzc(or_acc);
  assign zero_s  = (or_acc == {width_i{1'b0}});

  // Next-state decode and selection of the element to present next.
  always_comb begin
    state_nxt = state;
    rd_sel    = {cnt_w{1'b0}};
    shamt     = {scale_w{1'b0}};
    case (state)
      FILL: begin
        if (accept && last_wr) state_nxt = SCALE;
        else                   state_nxt = FILL;
      end
      SCALE: begin
        state_nxt = DRAIN;
        shamt     = zero_s ? {scale_w{1'b0}} : lz_s;
      end
      DRAIN: begin
        rd_sel = rd_nxt;
        shamt  = o_zero_blk ? {scale_w{1'b0}} : lz_min;
        if (xfer && last_rd) state_nxt = FILL;
        else                 state_nxt = DRAIN;
      end
      default: state_nxt = FILL;
    endcase
    mag_next  = buffer[rd_sel][width_i-1:0] << shamt;
    sign_next = buffer[rd_sel][width_i];
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= FILL;
    else       state <= state_nxt;
  end

  // Element storage; contents are not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && accept) buffer[wr_cnt] <= {i_sign, i_num};
  end

  // Counters, block statistics and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_cnt     <= {cnt_w{1'b0}};
      rd_cnt     <= {cnt_w{1'b0}};
      or_acc     <= {width_i{1'b0}};
      lz_min     <= {scale_w{1'b0}};
      o_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_num      <= {width_i{1'b0}};
      o_sign     <= 1'b0;
      o_shift    <= {width_shift{1'b0}};
      o_scale    <= {scale_w{1'b0}};
      o_zero_blk <= 1'b0;
      o_last     <= 1'b0;
    end else begin
      o_ready <= (state_nxt == FILL);
      o_valid <= (state_nxt == DRAIN);
      case (state)
        FILL: begin
          if (accept) begin
            or_acc <= or_acc | i_num;
            if (last_wr) begin
              wr_cnt  <= {cnt_w{1'b0}};
              o_shift <= i_shift_cfg;
            end else begin
              wr_cnt <= wr_cnt + {{(cnt_w-1){1'b0}}, 1'b1};
            end
          end
        end
        SCALE: begin
          lz_min     <= lz_s;
          o_scale    <= zero_s ? {scale_w{1'b0}} : (scale_w'(width_i - 1) - lz_s);
          o_zero_blk <= zero_s;
          o_num      <= mag_next;
          o_sign     <= sign_next;
          o_last     <= 1'b0;
        end
        DRAIN: begin
          if (xfer) begin
            if (last_rd) begin
              rd_cnt     <= {cnt_w{1'b0}};
              or_acc     <= {width_i{1'b0}};
              o_zero_blk <= 1'b0;
              o_last     <= 1'b0;
            end else begin
              rd_cnt <= rd_nxt;
              o_num  <= mag_next;
              o_sign <= sign_next;
              o_last <= (rd_nxt == cnt_w'(block_size - 1));
            end
          end
        end
        default: begin
          wr_cnt <= {cnt_w{1'b0}};
          rd_cnt <= {cnt_w{1'b0}};
        end
      endcase
    end
  end

endmodule
